// File: rtl/leg4_pkg.sv
// Shared types and constants for the leg4 top level and its matrix-input blocks.
// Holds the keypad FSM state type, the one-hot classifier result and keypad geometry.
package leg4_pkg;

    localparam int KP_COLS    = 4;
    localparam int KP_ROWS    = 4;
    localparam int KP_FRAME_W = KP_COLS * KP_ROWS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        LOCK = 2'd2
    } kp_state_t;

    typedef enum logic [1:0] {
        KP_NONE   = 2'd0,
        KP_SINGLE = 2'd1,
        KP_MULTI  = 2'd2
    } kp_class_t;

endpackage

// File: rtl/keypad_scan_if.sv
// Keypad matrix and key-event bundle between keypad_scan and its surroundings.
// row: active-low returns into the scanner; col: active-low strobes; key/key_valid/key_down: events.
interface keypad_scan_if;

    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       key_valid;
    logic       key_down;

    modport master (
        input  row,
        output col,
        output key,
        output key_valid,
        output key_down
    );

    modport slave (
        output row,
        input  col,
        input  key,
        input  key_valid,
        input  key_down
    );

endinterface

// File: rtl/clkdiv.sv
// Free-running prescaler: counts 0..max and flags the terminal count for one cycle.
// Ports: clk, rst (sync, active-high), tc (high while the count equals max).
module clkdiv #(
    parameter logic [23:0] max = 24'd11999
) (
    input  logic clk,
    input  logic rst,
    output logic tc
);

    logic [23:0] r_cnt;
    logic        w_tc;

    assign w_tc = (r_cnt == max);
    assign tc   = w_tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 24'd1;
        end
    end

endmodule

// File: rtl/kp_onehot16.sv
// Combinational classifier for a 16-bit matrix image: none / single / multi plus key code.
// Ports: i_vec (one bit per key), o_class (classification), o_code (index of the set bit).
module kp_onehot16
    import leg4_pkg::*;
(
    input  logic [15:0] i_vec,
    output kp_class_t   o_class,
    output logic [3:0]  o_code
);

    logic [4:0] w_cnt;
    logic [3:0] w_code;

    always_comb begin
        w_cnt  = '0;
        w_code = '0;
        for (int i = 0; i < 16; i++) begin
            if (i_vec[i]) begin
                w_cnt  = w_cnt + 5'd1;
                w_code = 4'(i);
            end
        end
    end

    always_comb begin
        o_code = w_code;
        unique case (1'b1)
            (w_cnt == 5'd0): o_class = KP_NONE;
            (w_cnt == 5'd1): o_class = KP_SINGLE;
            default:         o_class = KP_MULTI;
        endcase
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column strobing, row sync, frame debounce, single-key FSM.
// Ports: clk, rst (sync, active-high), bus (keypad_scan_if.master: row in, col/key/key_valid/key_down out).
module keypad_scan
    import leg4_pkg::*;
#(
    parameter logic [23:0] SCAN_MAX  = 24'd11999,
    parameter logic [2:0]  DEB_SCANS = 3'd4
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master bus
);

    logic            w_tick;
    logic [3:0]      r_sync1;
    logic [3:0]      r_rows_s;
    logic [1:0]      r_col_idx;
    logic [1:0]      w_col_idx_nxt;
    logic [3:0]      r_col;
    logic [15:0]     r_frame;
    logic [15:0]     w_new_frame;
    logic [15:0]     r_prev_frame;
    logic [15:0]     r_debounced;
    logic [2:0]      r_stable_cnt;
    logic [2:0]      w_cnt_inc;
    logic            w_frame_done;
    logic            w_match;
    logic            w_commit_now;
    logic            r_commit;
    kp_class_t       w_class;
    logic [3:0]      w_code;
    kp_state_t       r_state;
    kp_state_t       w_next_state;
    logic            w_accept;
    logic [3:0]      r_key;
    logic            r_key_valid;
    logic            r_key_down;

    clkdiv #(
        .max (SCAN_MAX)
    ) u_div (
        .clk (clk),
        .rst (rst),
        .tc  (w_tick)
    );

    // Rows are active-low and asynchronous; invert then double-flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= '0;
            r_rows_s <= '0;
        end else begin
            r_sync1  <= ~bus.row;
            r_rows_s <= r_sync1;
        end
    end

    // Frame image with the current column's slice replaced by the synced rows.
    always_comb begin
        w_new_frame = r_frame;
        w_new_frame[{r_col_idx, 2'b00} +: 4] = r_rows_s;
    end

    assign w_col_idx_nxt = r_col_idx + 2'd1;
    assign w_frame_done  = w_tick && (r_col_idx == 2'd3);
    assign w_match       = (w_new_frame == r_prev_frame);
    assign w_cnt_inc     = (r_stable_cnt == DEB_SCANS) ? DEB_SCANS
                                                       : r_stable_cnt + 3'd1;
    // Commit only on the transition into saturation, never while parked there.
    assign w_commit_now  = w_frame_done && w_match
                        && (r_stable_cnt == DEB_SCANS - 3'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_idx <= '0;
            r_col     <= 4'b1110;
            r_frame   <= '0;
        end else if (w_tick) begin
            r_frame   <= w_new_frame;
            r_col_idx <= w_col_idx_nxt;
            r_col     <= ~(4'b0001 << w_col_idx_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_frame <= '0;
            r_stable_cnt <= '0;
            r_debounced  <= '0;
            r_commit     <= 1'b0;
        end else begin
            r_commit <= w_commit_now;
            if (w_frame_done) begin
                r_prev_frame <= w_new_frame;
                r_stable_cnt <= w_match ? w_cnt_inc : 3'd0;
            end
            if (w_commit_now) begin
                r_debounced <= w_new_frame;
            end
        end
    end

    kp_onehot16 u_cls (
        .i_vec   (r_debounced),
        .o_class (w_class),
        .o_code  (w_code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (r_commit) begin
            unique case (r_state)
                IDLE: begin
                    if (w_class == KP_SINGLE) begin
                        w_next_state = DOWN;
                    end else if (w_class == KP_MULTI) begin
                        w_next_state = LOCK;
                    end
                end
                DOWN: begin
                    if (w_class == KP_NONE) begin
                        w_next_state = IDLE;
                    end else if (w_class != KP_SINGLE || w_code != r_key) begin
                        w_next_state = LOCK;
                    end
                end
                LOCK: begin
                    if (w_class == KP_NONE) begin
                        w_next_state = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        w_accept = r_commit && (r_state == IDLE) && (w_class == KP_SINGLE);
    end

    // key_down tracks the state being entered so it rises with key_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key       <= '0;
            r_key_valid <= 1'b0;
            r_key_down  <= 1'b0;
        end else begin
            r_key_valid <= w_accept;
            r_key_down  <= (w_next_state == DOWN);
            if (w_accept) begin
                r_key <= w_code;
            end
        end
    end

    assign bus.col       = r_col;
    assign bus.key       = r_key;
    assign bus.key_valid = r_key_valid;
    assign bus.key_down  = r_key_down;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a small matrix model (SCAN_MAX=3, DEB_SCANS=2).
// Frame = 16 cycles; key pulses are counted on posedge and compared as deltas.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pressed = '0;
    logic [3:0]  w_rows;
    int          n_checks = 0;
    int          n_fail = 0;
    int          pulses = 0;
    logic [3:0]  last_key = '0;
    int          base;
    int          k;
    logic        found;

    keypad_scan_if kp_if ();

    keypad_scan #(
        .SCAN_MAX  (24'd3),
        .DEB_SCANS (3'd2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (kp_if)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        w_rows = '0;
        for (int c = 0; c < 4; c++) begin
            if (!kp_if.col[c]) begin
                w_rows = w_rows | pressed[c*4 +: 4];
            end
        end
        kp_if.row = ~w_rows;
    end

    always @(posedge clk) begin
        if (kp_if.key_valid) begin
            pulses   <= pulses + 1;
            last_key <= kp_if.key;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Park on the first negedge after a frame boundary (col just became 1110).
    task automatic frame_start();
        int t;
        t = 0;
        while (kp_if.col != 4'b0111 && t < 40) begin
            @(negedge clk);
            t++;
        end
        while (kp_if.col != 4'b1110 && t < 80) begin
            @(negedge clk);
            t++;
        end
        chk("frame_sync", {28'd0, kp_if.col}, 32'hE);
    endtask

    initial begin
        // 1: reset and idle scanning
        cyc(3);
        chk("rst_col", {28'd0, kp_if.col}, 32'hE);
        chk("rst_key", {28'd0, kp_if.key}, 32'h0);
        chk("rst_valid", {31'd0, kp_if.key_valid}, 32'h0);
        chk("rst_down", {31'd0, kp_if.key_down}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            logic [3:0] one;
            one = 4'b0001;
            chk("col_seq", {28'd0, kp_if.col},
                {28'd0, ~(one << ((i / 4) % 4))});
            @(negedge clk);
        end
        base = pulses;
        cyc(200);
        chk("idle_pulses", pulses - base, 0);
        chk("idle_key", {28'd0, kp_if.key}, 32'h0);
        chk("idle_down", {31'd0, kp_if.key_down}, 32'h0);

        // 2: key 9 (col 2 / row 1)
        frame_start();
        base = pulses;
        pressed = 16'h0200;
        found = 1'b0;
        k = 0;
        while (!found && k < 66) begin
            @(negedge clk);
            k++;
            found = kp_if.key_valid;
        end
        chk("t2_latency", {31'd0, found}, 32'h1);
        chk("t2_key", {28'd0, kp_if.key}, 32'h9);
        chk("t2_down", {31'd0, kp_if.key_down}, 32'h1);
        cyc(160 - k);
        chk("t2_pulses", pulses - base, 1);
        frame_start();
        pressed = '0;
        cyc(64);
        chk("t2_rel_down", {31'd0, kp_if.key_down}, 32'h0);
        chk("t2_rel_key", {28'd0, kp_if.key}, 32'h9);
        chk("t2_rel_pulses", pulses - base, 1);

        // 3: bouncy key 5
        base = pulses;
        for (int i = 0; i < 5; i++) begin
            pressed = pressed ^ 16'h0020;
            cyc(20);
        end
        chk("t3_bounce_none", pulses - base, 0);
        pressed = 16'h0020;
        cyc(96);
        chk("t3_pulses", pulses - base, 1);
        chk("t3_lastkey", {28'd0, last_key}, 32'h5);
        chk("t3_key", {28'd0, kp_if.key}, 32'h5);
        chk("t3_down", {31'd0, kp_if.key_down}, 32'h1);
        pressed = '0;
        cyc(80);
        chk("t3_rel_down", {31'd0, kp_if.key_down}, 32'h0);

        // 4: key 0 then key 15 added
        base = pulses;
        pressed = 16'h0001;
        cyc(96);
        chk("t4_first", pulses - base, 1);
        chk("t4_key0", {28'd0, kp_if.key}, 32'h0);
        chk("t4_down", {31'd0, kp_if.key_down}, 32'h1);
        pressed = 16'h8001;
        cyc(80);
        chk("t4_lock_down", {31'd0, kp_if.key_down}, 32'h0);
        chk("t4_lock_pulses", pulses - base, 1);
        pressed = 16'h0001;
        cyc(80);
        chk("t4_part_pulses", pulses - base, 1);
        chk("t4_part_down", {31'd0, kp_if.key_down}, 32'h0);
        pressed = '0;
        cyc(80);
        pressed = 16'h0040;
        cyc(96);
        chk("t4_idle_pulses", pulses - base, 2);
        chk("t4_idle_key", {28'd0, last_key}, 32'h6);
        chk("t4_idle_down", {31'd0, kp_if.key_down}, 32'h1);
        pressed = '0;
        cyc(80);

        // 5: reset while key 3 is held
        base = pulses;
        pressed = 16'h0008;
        cyc(96);
        chk("t5_pre_pulses", pulses - base, 1);
        chk("t5_pre_key", {28'd0, kp_if.key}, 32'h3);
        cyc(5);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_col", {28'd0, kp_if.col}, 32'hE);
        chk("t5_rst_key", {28'd0, kp_if.key}, 32'h0);
        chk("t5_rst_valid", {31'd0, kp_if.key_valid}, 32'h0);
        chk("t5_rst_down", {31'd0, kp_if.key_down}, 32'h0);
        rst = 1'b0;
        base = pulses;
        cyc(96);
        chk("t5_post_pulses", pulses - base, 1);
        chk("t5_post_key", {28'd0, kp_if.key}, 32'h3);
        chk("t5_post_down", {31'd0, kp_if.key_down}, 32'h1);

        // 6: back-to-back keys 7 then 12
        pressed = '0;
        cyc(80);
        base = pulses;
        pressed = 16'h0080;
        cyc(96);
        chk("t6_first_cnt", pulses - base, 1);
        chk("t6_first_key", {28'd0, last_key}, 32'h7);
        pressed = '0;
        cyc(80);
        pressed = 16'h1000;
        cyc(96);
        chk("t6_second_cnt", pulses - base, 2);
        chk("t6_second_key", {28'd0, last_key}, 32'hC);
        chk("t6_key", {28'd0, kp_if.key}, 32'hC);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
